// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite compositor and its per-sprite units.
package sprite_pkg;

    localparam int VGA_PIPE_EXTRA = 2;

    typedef logic [11:0] color_t;
    typedef logic [10:0] hcount_t;
    typedef logic [9:0]  vcount_t;

    typedef struct packed {
        hcount_t x;
        vcount_t y;
        logic    en;
    } sprite_pos_t;

endpackage

// File: rtl/sprite_unit.sv
// One sprite channel: frame-latched position, hit test, memory address
// register and the inside-bit pipe aligned with the memory read data.
module sprite_unit
    import sprite_pkg::*;
#(
    parameter int SPRITE_W    = 128,
    parameter int SPRITE_H    = 128,
    parameter int MEM_LATENCY = 2,
    parameter int LOG_W       = $clog2(SPRITE_W),
    parameter int LOG_H       = $clog2(SPRITE_H),
    parameter int ADDR_W      = LOG_W + LOG_H
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              latch,
    input  hcount_t           hcount,
    input  vcount_t           vcount,
    input  hcount_t           pos_x,
    input  vcount_t           pos_y,
    input  logic              enable,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              inside_dly
);

    sprite_pos_t          shadow_r;
    logic [11:0]          x_end_s;
    logic [10:0]          y_end_s;
    logic                 inside_s;
    logic [LOG_W-1:0]     dx_s;
    logic [LOG_H-1:0]     dy_s;
    logic [MEM_LATENCY:0] inside_pipe_r;

    // Shadow position: only updated at the frame latch so a frame never tears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_r <= '0;
        end else if (latch) begin
            shadow_r <= {pos_x, pos_y, enable};
        end
    end

    // Hit test with one extra bit on the far edges so sprites near 2047/1023 clip
    // instead of wrapping; offsets only need the low address bits.
    always_comb begin
        x_end_s  = {1'b0, shadow_r.x} + 12'(SPRITE_W);
        y_end_s  = {1'b0, shadow_r.y} + 11'(SPRITE_H);
        inside_s = shadow_r.en
                   && (hcount >= shadow_r.x) && ({1'b0, hcount} < x_end_s)
                   && (vcount >= shadow_r.y) && ({1'b0, vcount} < y_end_s);
        dx_s     = hcount[LOG_W-1:0] - shadow_r.x[LOG_W-1:0];
        dy_s     = vcount[LOG_H-1:0] - shadow_r.y[LOG_H-1:0];
    end

    // Read address, held while the beam is outside the sprite.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr <= '0;
        end else if (inside_s) begin
            mem_addr <= {dy_s, dx_s};
        end
    end

    // Inside bit delayed to line up with the returned pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inside_pipe_r <= '0;
        end else begin
            inside_pipe_r <= {inside_pipe_r[MEM_LATENCY-1:0], inside_s};
        end
    end

    assign inside_dly = inside_pipe_r[MEM_LATENCY];

endmodule

// File: rtl/sprite_compositor.sv
// Multi-sprite compositor: per-sprite address generation, fixed-priority
// transparent compositing, matched sync delay and frame collision flag.
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int                 N_SPRITES   = 2,
    parameter int                 SPRITE_W    = 128,
    parameter int                 SPRITE_H    = 128,
    parameter int                 COLOR_W     = 12,
    parameter int                 MEM_LATENCY = 2,
    parameter bit                 KEY_EN      = 1'b1,
    parameter logic [COLOR_W-1:0] KEY_COLOR   = 12'h000,
    parameter logic [COLOR_W-1:0] BG_COLOR    = 12'h000,
    localparam int                ADDR_W      = $clog2(SPRITE_W) + $clog2(SPRITE_H)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [10:0]                   hcount_in,
    input  logic [9:0]                    vcount_in,
    input  logic                          hsync_in,
    input  logic                          vsync_in,
    input  logic                          blank_in,
    input  logic [N_SPRITES*11-1:0]       pos_x_in,
    input  logic [N_SPRITES*10-1:0]       pos_y_in,
    input  logic [N_SPRITES-1:0]          enable_in,
    output logic [N_SPRITES*ADDR_W-1:0]   mem_addr_out,
    input  logic [N_SPRITES*COLOR_W-1:0]  mem_dout_in,
    output logic [COLOR_W-1:0]            color_out,
    output logic                          hsync_out,
    output logic                          vsync_out,
    output logic                          blank_out,
    output logic [N_SPRITES-1:0]          hit_out,
    output logic                          collision_out
);

    localparam int L = MEM_LATENCY + VGA_PIPE_EXTRA;

    logic                 vsync_prev_r;
    logic                 latch_s;
    logic [N_SPRITES-1:0] inside_dly_s;
    logic [L-1:0]         hsync_pipe_r;
    logic [L-1:0]         vsync_pipe_r;
    logic [L-1:0]         blank_pipe_r;
    logic [N_SPRITES-1:0] opaque_s;
    logic [N_SPRITES-1:0] win_s;
    logic [COLOR_W-1:0]   color_s;
    logic [3:0]           n_opaque_s;
    logic                 found_s;
    logic                 stage_blank_s;
    logic                 coll_s;
    logic                 coll_acc_r;

    assign latch_s       = vsync_in & ~vsync_prev_r;
    assign stage_blank_s = blank_pipe_r[L-2];

    // Previous vsync resets high so a reset released during vsync is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_prev_r <= 1'b1;
        end else begin
            vsync_prev_r <= vsync_in;
        end
    end

    for (genvar g = 0; g < N_SPRITES; g++) begin : g_unit
        sprite_unit #(
            .SPRITE_W   (SPRITE_W),
            .SPRITE_H   (SPRITE_H),
            .MEM_LATENCY(MEM_LATENCY),
            .ADDR_W     (ADDR_W)
        ) u_unit (
            .clk       (clk),
            .rst_n     (rst_n),
            .latch     (latch_s),
            .hcount    (hcount_in),
            .vcount    (vcount_in),
            .pos_x     (pos_x_in[g*11 +: 11]),
            .pos_y     (pos_y_in[g*10 +: 10]),
            .enable    (enable_in[g]),
            .mem_addr  (mem_addr_out[g*ADDR_W +: ADDR_W]),
            .inside_dly(inside_dly_s[g])
        );
    end

    // Timing signals delayed by the full pixel latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_pipe_r <= '0;
            vsync_pipe_r <= '0;
            blank_pipe_r <= '1;
        end else begin
            hsync_pipe_r <= {hsync_pipe_r[L-2:0], hsync_in};
            vsync_pipe_r <= {vsync_pipe_r[L-2:0], vsync_in};
            blank_pipe_r <= {blank_pipe_r[L-2:0], blank_in};
        end
    end

    assign hsync_out = hsync_pipe_r[L-1];
    assign vsync_out = vsync_pipe_r[L-1];
    assign blank_out = blank_pipe_r[L-1];

    // Opacity, lowest-index priority and opaque count at the compose stage.
    always_comb begin
        opaque_s   = '0;
        win_s      = '0;
        color_s    = BG_COLOR;
        n_opaque_s = 4'd0;
        found_s    = 1'b0;
        for (int i = 0; i < N_SPRITES; i++) begin
            if (inside_dly_s[i]
                && !((KEY_EN == 1'b1) && (mem_dout_in[i*COLOR_W +: COLOR_W] == KEY_COLOR))) begin
                opaque_s[i] = 1'b1;
            end else begin
                opaque_s[i] = 1'b0;
            end
            n_opaque_s = n_opaque_s + {3'b000, opaque_s[i]};
            if (opaque_s[i] && !found_s) begin
                found_s  = 1'b1;
                win_s[i] = 1'b1;
                color_s  = mem_dout_in[i*COLOR_W +: COLOR_W];
            end else begin
                win_s[i] = 1'b0;
            end
        end
        coll_s = (n_opaque_s >= 4'd2) && !stage_blank_s;
    end

    // Compose register; blanking suppresses both colour and hit flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            color_out <= '0;
            hit_out   <= '0;
        end else if (stage_blank_s) begin
            color_out <= '0;
            hit_out   <= '0;
        end else begin
            color_out <= color_s;
            hit_out   <= win_s;
        end
    end

    // Frame collision: publish at the latch; a hit in the latch cycle opens the new frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll_acc_r    <= 1'b0;
            collision_out <= 1'b0;
        end else if (latch_s) begin
            collision_out <= coll_acc_r;
            coll_acc_r    <= coll_s;
        end else begin
            coll_acc_r    <= coll_acc_r | coll_s;
        end
    end

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed and randomized bench for sprite_compositor against a frame-level
// reference model (shadow positions, ROM lookups, priority and collision rules).
module tb_sprite_compositor;
    import sprite_pkg::*;

    localparam int N  = 2;
    localparam int W  = 128;
    localparam int H  = 128;
    localparam int ML = 2;
    localparam int L  = ML + 2;
    localparam int AW = 14;
    localparam logic [11:0] KEY = 12'h000;
    localparam logic [11:0] BG  = 12'h0F0;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [10:0]     hcount_in;
    logic [9:0]      vcount_in;
    logic            hsync_in, vsync_in, blank_in;
    logic [N*11-1:0] pos_x_in;
    logic [N*10-1:0] pos_y_in;
    logic [N-1:0]    enable_in;
    logic [N*AW-1:0] mem_addr_out;
    logic [N*12-1:0] mem_dout_in;
    logic [11:0]     color_out;
    logic            hsync_out, vsync_out, blank_out;
    logic [N-1:0]    hit_out;
    logic            collision_out;

    sprite_compositor #(
        .N_SPRITES(N), .SPRITE_W(W), .SPRITE_H(H), .COLOR_W(12), .MEM_LATENCY(ML),
        .KEY_EN(1'b1), .KEY_COLOR(KEY), .BG_COLOR(BG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in),
        .pos_x_in(pos_x_in), .pos_y_in(pos_y_in), .enable_in(enable_in),
        .mem_addr_out(mem_addr_out), .mem_dout_in(mem_dout_in), .color_out(color_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .blank_out(blank_out),
        .hit_out(hit_out), .collision_out(collision_out)
    );

    always #5 clk = ~clk;

    // Sprite memories with a fixed two-cycle read latency.
    logic [11:0]     rom [N][W*H];
    logic [N*12-1:0] mem_d1, mem_d2;
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) mem_d1[i*12 +: 12] <= rom[i][mem_addr_out[i*AW +: AW]];
        mem_d2 <= mem_d1;
    end
    assign mem_dout_in = mem_d2;

    typedef struct {
        logic [11:0] color;
        logic [N-1:0] hit;
        logic hs, vs, bl, coll;
    } exp_t;

    exp_t q[$];
    int   sh_x[N], sh_y[N], m_addr[N];
    bit   sh_en[N];
    bit   m_vs_prev, m_acc, m_coll;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            sh_x[i] = 0; sh_y[i] = 0; sh_en[i] = 1'b0; m_addr[i] = 0;
        end
        m_vs_prev = 1'b1; m_acc = 1'b0; m_coll = 1'b0;
        q.delete();
        repeat (L - 1) q.push_back('{12'h000, '0, 1'b0, 1'b0, 1'b1, 1'b0});
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_color"}, 32'(color_out), 32'h0);
        check({tag, "_hsync"}, 32'(hsync_out), 32'h0);
        check({tag, "_vsync"}, 32'(vsync_out), 32'h0);
        check({tag, "_blank"}, 32'(blank_out), 32'h1);
        check({tag, "_addr"},  32'(mem_addr_out), 32'h0);
        check({tag, "_hit"},   32'(hit_out), 32'h0);
        check({tag, "_coll"},  32'(collision_out), 32'h0);
    endtask

    task automatic set_pos(input int i, input int x, input int y, input bit en);
        pos_x_in[i*11 +: 11] = 11'(x);
        pos_y_in[i*10 +: 10] = 10'(y);
        enable_in[i]         = en;
    endtask

    // One pixel clock: drive inputs, predict, then compare the outputs due now.
    task automatic step(input int h, input int v, input bit hs, input bit vs, input bit bl);
        exp_t e, e0;
        int cnt;
        bit found, ins;
        logic [11:0] pix;
        hcount_in = 11'(h); vcount_in = 10'(v);
        hsync_in = hs; vsync_in = vs; blank_in = bl;
        e.color = bl ? 12'h000 : BG; e.hit = '0;
        e.hs = hs; e.vs = vs; e.bl = bl;
        cnt = 0; found = 1'b0;
        for (int i = 0; i < N; i++) begin
            ins = sh_en[i] && h >= sh_x[i] && h < sh_x[i] + W && v >= sh_y[i] && v < sh_y[i] + H;
            if (ins) begin
                m_addr[i] = (v - sh_y[i]) * W + (h - sh_x[i]);
                pix = rom[i][m_addr[i]];
                if (pix != KEY) begin
                    cnt++;
                    if (!found) begin
                        found = 1'b1;
                        if (!bl) begin
                            e.color = pix; e.hit[i] = 1'b1;
                        end
                    end
                end
            end
        end
        e.coll = !bl && cnt >= 2;
        q.push_back(e);
        if (vs && !m_vs_prev) begin
            m_coll = m_acc;
            m_acc  = q[0].coll;
            for (int i = 0; i < N; i++) begin
                sh_x[i]  = int'(pos_x_in[i*11 +: 11]);
                sh_y[i]  = int'(pos_y_in[i*10 +: 10]);
                sh_en[i] = enable_in[i];
            end
        end else begin
            m_acc = m_acc | q[0].coll;
        end
        m_vs_prev = vs;
        @(posedge clk); #1;
        e0 = q.pop_front();
        check("color", 32'(color_out), 32'(e0.color));
        check("hit", 32'(hit_out), 32'(e0.hit));
        check("hsync", 32'(hsync_out), 32'(e0.hs));
        check("vsync", 32'(vsync_out), 32'(e0.vs));
        check("blank", 32'(blank_out), 32'(e0.bl));
        check("collision", 32'(collision_out), 32'(m_coll));
        for (int i = 0; i < N; i++)
            check($sformatf("addr%0d", i), 32'(mem_addr_out[i*AW +: AW]), 32'(m_addr[i]));
    endtask

    task automatic frame_end();
        repeat (L) step(1400, 800, 1'b0, 1'b0, 1'b1);
        step(1400, 801, 1'b0, 1'b1, 1'b1);
        step(1400, 801, 1'b0, 1'b1, 1'b1);
        step(1400, 802, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic fill_random_roms();
        for (int i = 0; i < N; i++)
            for (int a = 0; a < W*H; a++)
                rom[i][a] = ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom);
    endtask

    initial begin
        for (int a = 0; a < W*H; a++) begin
            rom[0][a] = 12'(a);
            rom[1][a] = 12'($urandom);
        end
        rst_n = 1'b0;
        hcount_in = '0; vcount_in = '0;
        hsync_in = 1'b0; vsync_in = 1'b0; blank_in = 1'b1;
        pos_x_in = '0; pos_y_in = '0; enable_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("por");
        rst_n = 1'b1;
        model_reset();

        // Single sprite at the origin; ROM pixel equals its address.
        set_pos(0, 0, 0, 1'b1);
        set_pos(1, 0, 0, 1'b0);
        frame_end();
        step(5, 3, 1'b1, 1'b0, 1'b0);
        check("addr_389", 32'(mem_addr_out[AW-1:0]), 32'd389);
        repeat (L - 1) step(600, 600, 1'b0, 1'b0, 1'b0);
        check("color_185", 32'(color_out), 32'h185);
        check("hsync_lat", 32'(hsync_out), 32'h1);
        repeat (40) step($urandom_range(0, 199), $urandom_range(0, 199), 1'b0, 1'b0,
                         $urandom_range(0, 7) == 0);

        // Staged position change mid-frame waits for the next latch.
        set_pos(0, 100, 0, 1'b1);
        step(50, 0, 1'b0, 1'b0, 1'b0);
        check("addr_old_pos", 32'(mem_addr_out[AW-1:0]), 32'd50);
        repeat (30) step($urandom_range(0, 255), $urandom_range(0, 150), 1'b0, 1'b0, 1'b0);
        frame_end();
        step(100, 0, 1'b0, 1'b0, 1'b0);
        check("addr_new_pos", 32'(mem_addr_out[AW-1:0]), 32'd0);
        step(101, 0, 1'b0, 1'b0, 1'b0);
        check("addr_new_pos1", 32'(mem_addr_out[AW-1:0]), 32'd1);

        // Priority / transparency with both sprites stacked at the origin.
        rom[1][0] = 12'h0AB;
        rom[1][1] = 12'h0CD;
        set_pos(0, 0, 0, 1'b1);
        set_pos(1, 0, 0, 1'b1);
        frame_end();
        step(0, 0, 1'b0, 1'b0, 1'b0);
        step(1, 0, 1'b0, 1'b0, 1'b0);
        step(700, 700, 1'b0, 1'b0, 1'b0);
        step(700, 700, 1'b0, 1'b0, 1'b0);
        check("key_color", 32'(color_out), 32'h0AB);
        check("key_hit", 32'(hit_out), 32'h2);
        step(700, 700, 1'b0, 1'b0, 1'b0);
        check("prio_color", 32'(color_out), 32'h001);
        check("prio_hit", 32'(hit_out), 32'h1);

        // Collision flag follows the frame that produced it.
        set_pos(1, 500, 500, 1'b1);
        frame_end();
        check("coll_set", 32'(collision_out), 32'h1);
        repeat (40) step($urandom_range(0, 200), $urandom_range(0, 200), 1'b0, 1'b0, 1'b0);
        frame_end();
        check("coll_clear", 32'(collision_out), 32'h0);

        // Right-edge clipping.
        set_pos(0, 2000, 0, 1'b1);
        set_pos(1, 0, 0, 1'b0);
        frame_end();
        for (int h = 0; h < 128; h += 8) step(h, $urandom_range(0, 127), 1'b0, 1'b0, 1'b0);
        repeat (L - 1) step(1999, 5, 1'b0, 1'b0, 1'b0);
        check("clip_bg", 32'(color_out), 32'(BG));
        repeat (20) step($urandom_range(1990, 2047), $urandom_range(0, 130), 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a line.
        set_pos(0, 0, 0, 1'b1);
        frame_end();
        repeat (10) step($urandom_range(0, 127), $urandom_range(0, 127), 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_reset_values("midline");
        repeat (2) @(posedge clk);
        #1 check_reset_values("held");
        rst_n = 1'b1;
        model_reset();
        repeat (L + 2) step(10, 10, 1'b0, 1'b0, 1'b0);
        check("post_reset_bg", 32'(color_out), 32'(BG));
        frame_end();

        // Randomized frames.
        for (int f = 0; f < 8; f++) begin
            fill_random_roms();
            for (int i = 0; i < N; i++)
                set_pos(i, ($urandom_range(0, 4) == 0) ? $urandom_range(1950, 2047) : $urandom_range(0, 300),
                        ($urandom_range(0, 4) == 0) ? $urandom_range(950, 1023) : $urandom_range(0, 300),
                        $urandom_range(0, 3) != 0);
            frame_end();
            for (int p = 0; p < 150; p++) begin
                if (p == 75)
                    set_pos($urandom_range(0, N - 1), $urandom_range(0, 300), $urandom_range(0, 300), 1'b1);
                step(($urandom_range(0, 5) == 0) ? $urandom_range(1900, 2047) : $urandom_range(0, 450),
                     ($urandom_range(0, 5) == 0) ? $urandom_range(900, 1023) : $urandom_range(0, 450),
                     $urandom_range(0, 15) == 0, 1'b0, $urandom_range(0, 7) == 0);
            end
        end
        frame_end();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
